// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch slice: word type, fetch FSM states, PC step.
package fetch_unit_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    PENDING = 2'd1,
    HALTED  = 2'd2
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

  function automatic word_t align_word(word_t a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem request/response, hazard/redirect controls, IF/ID feed.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic  ihit;
  word_t imemload;
  logic  stall;
  logic  redirect_en;
  word_t redirect_pc;
  logic  halt;
  logic  iREN;
  word_t imemaddr;
  word_t iload_o;
  word_t npc_o;
  logic  iien;

  modport master (
    input  ihit, imemload, stall, redirect_en, redirect_pc, halt,
    output iREN, imemaddr, iload_o, npc_o, iien
  );

  modport slave (
    output ihit, imemload, stall, redirect_en, redirect_pc, halt,
    input  iREN, imemaddr, iload_o, npc_o, iien
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues imem reads, feeds IF/ID in the hit cycle,
// parks redirects that land during a miss and stops for good on halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input logic          CLK,
  input logic          RST,
  fetch_unit_if.master bus
);

  word_t        pc, pc_n;
  word_t        tgt, tgt_n;
  fetch_state_t st, st_n;
  word_t        rpc;

  assign rpc = align_word(bus.redirect_pc);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc  <= PC_INIT;
      tgt <= '0;
      st  <= FETCH;
    end else begin
      pc  <= pc_n;
      tgt <= tgt_n;
      st  <= st_n;
    end
  end

  always_comb begin
    pc_n  = pc;
    tgt_n = tgt;
    st_n  = st;
    case (st)
      FETCH: begin
        if (bus.halt) st_n = HALTED;
        else if (bus.redirect_en) begin
          if (bus.ihit) pc_n = rpc;
          else begin
            tgt_n = rpc;
            st_n  = PENDING;
          end
        end else if (bus.ihit && !bus.stall) pc_n = pc + PC_STEP;
      end
      PENDING: begin
        // The returning word belongs to the abandoned path; steer to the newest target.
        if (bus.halt) st_n = HALTED;
        else begin
          if (bus.redirect_en) tgt_n = rpc;
          if (bus.ihit) begin
            pc_n = bus.redirect_en ? rpc : tgt;
            st_n = FETCH;
          end
        end
      end
      HALTED:  ;
      default: st_n = FETCH;
    endcase
  end

  always_comb begin
    bus.imemaddr = pc;
    bus.iload_o  = bus.imemload;
    bus.npc_o    = pc + PC_STEP;
    bus.iREN     = !RST && (st != HALTED);
    bus.iien     = !RST && (st == FETCH) && bus.ihit && !bus.stall &&
                   !bus.redirect_en && !bus.halt;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a reference model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam word_t PC_INIT = 32'h0000_0000;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_unit_if bus ();

  fetch_unit #(.PC_INIT(PC_INIT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic ih, input logic stl, input logic re,
                        input word_t rpc, input logic h);
    bus.ihit        = ih;
    bus.stall       = stl;
    bus.redirect_en = re;
    bus.redirect_pc = rpc;
    bus.halt        = h;
    bus.imemload    = $urandom;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    n_tests++;
    if (bus.iREN !== 1'b0) begin n_fail++; $display("FAIL reset_iren got %b exp 0", bus.iREN); end
    n_tests++;
    if (bus.iien !== 1'b0) begin n_fail++; $display("FAIL reset_iien got %b exp 0", bus.iien); end
    n_tests++;
    if (bus.imemaddr !== PC_INIT) begin n_fail++; $display("FAIL reset_addr got %h exp %h", bus.imemaddr, PC_INIT); end
    tick();
    RST = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      #2;
      n_tests++;
      if (bus.imemaddr !== word_t'(i * 4) || bus.iien !== 1'b1 || bus.npc_o !== word_t'(i * 4 + 4) ||
          bus.iload_o !== bus.imemload)
        begin n_fail++; $display("FAIL seq[%0d] got addr %h iien %b npc %h exp addr %h iien 1 npc %h",
                                 i, bus.imemaddr, bus.iien, bus.npc_o, i * 4, i * 4 + 4); end
      tick();
    end
  endtask

  task automatic test_miss();
    for (int i = 0; i < 4; i++) begin
      set_in(i == 3, 1'b0, 1'b0, 32'h0, 1'b0);
      #2;
      n_tests++;
      if (bus.imemaddr !== 32'h10 || bus.iien !== (i == 3) || bus.iREN !== 1'b1)
        begin n_fail++; $display("FAIL miss[%0d] got addr %h iien %b exp addr 10 iien %b",
                                 i, bus.imemaddr, bus.iien, i == 3); end
      tick();
    end
    n_tests++;
    if (bus.imemaddr !== 32'h14) begin n_fail++; $display("FAIL miss_after got %h exp 14", bus.imemaddr); end
  endtask

  task automatic test_stall();
    set_in(1'b1, 1'b0, 1'b1, 32'h20, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      #2;
      n_tests++;
      if (bus.imemaddr !== 32'h20 || bus.iien !== 1'b0)
        begin n_fail++; $display("FAIL stall[%0d] got addr %h iien %b exp addr 20 iien 0", i, bus.imemaddr, bus.iien); end
      tick();
    end
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    n_tests++;
    if (bus.imemaddr !== 32'h20 || bus.iien !== 1'b1)
      begin n_fail++; $display("FAIL stall_release got addr %h iien %b exp addr 20 iien 1", bus.imemaddr, bus.iien); end
    tick();
    n_tests++;
    if (bus.imemaddr !== 32'h24) begin n_fail++; $display("FAIL stall_adv got %h exp 24", bus.imemaddr); end
  endtask

  task automatic test_redirect();
    set_in(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
    tick();
    // single redirect during a miss, misaligned target
    set_in(1'b0, 1'b0, 1'b1, 32'h103, 1'b0);
    #2;
    n_tests++;
    if (bus.imemaddr !== 32'h40 || bus.iien !== 1'b0)
      begin n_fail++; $display("FAIL redir_cap got addr %h iien %b exp addr 40 iien 0", bus.imemaddr, bus.iien); end
    tick();
    for (int i = 0; i < 2; i++) begin
      set_in(i == 1, 1'b0, 1'b0, 32'h0, 1'b0);
      #2;
      n_tests++;
      if (bus.imemaddr !== 32'h40 || bus.iien !== 1'b0)
        begin n_fail++; $display("FAIL redir_wait[%0d] got addr %h iien %b exp addr 40 iien 0", i, bus.imemaddr, bus.iien); end
      tick();
    end
    n_tests++;
    if (bus.imemaddr !== 32'h100) begin n_fail++; $display("FAIL redir_tgt got %h exp 100", bus.imemaddr); end
    // two redirects inside one miss: the later wins
    set_in(1'b0, 1'b0, 1'b1, 32'h150, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 32'h202, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    #2;
    n_tests++;
    if (bus.imemaddr !== 32'h100 || bus.iien !== 1'b0)
      begin n_fail++; $display("FAIL redir2_hit got addr %h iien %b exp addr 100 iien 0", bus.imemaddr, bus.iien); end
    tick();
    n_tests++;
    if (bus.imemaddr !== 32'h200) begin n_fail++; $display("FAIL redir2_tgt got %h exp 200", bus.imemaddr); end
  endtask

  task automatic test_halt();
    word_t p;
    p = bus.imemaddr;
    set_in(1'b1, 1'b0, 1'b1, 32'h300, 1'b1);
    #2;
    n_tests++;
    if (bus.iien !== 1'b0) begin n_fail++; $display("FAIL halt_iien got %b exp 0", bus.iien); end
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
      #2;
      n_tests++;
      if (bus.iREN !== 1'b0 || bus.iien !== 1'b0 || bus.imemaddr !== p)
        begin n_fail++; $display("FAIL halted[%0d] got iren %b iien %b addr %h exp 0 0 %h",
                                 i, bus.iREN, bus.iien, bus.imemaddr, p); end
      tick();
    end
    test_reset();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    n_tests++;
    if (bus.imemaddr !== PC_INIT || bus.iREN !== 1'b1)
      begin n_fail++; $display("FAIL halt_restart got addr %h iren %b exp %h 1", bus.imemaddr, bus.iREN, PC_INIT); end
    tick();
  endtask

  task automatic test_wrap_reset();
    set_in(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    n_tests++;
    if (bus.imemaddr !== 32'hFFFF_FFFC || bus.npc_o !== 32'h0 || bus.iien !== 1'b1)
      begin n_fail++; $display("FAIL wrap got addr %h npc %h iien %b exp FFFFFFFC 0 1", bus.imemaddr, bus.npc_o, bus.iien); end
    tick();
    n_tests++;
    if (bus.imemaddr !== 32'h0) begin n_fail++; $display("FAIL wrap_next got %h exp 0", bus.imemaddr); end
    set_in(1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 32'h500, 1'b0);
    tick();
    // reset lands while the redirected miss is still outstanding
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    RST = 1'b1;
    #1;
    n_tests++;
    if (bus.iREN !== 1'b0 || bus.imemaddr !== PC_INIT)
      begin n_fail++; $display("FAIL rst_mid got iren %b addr %h exp 0 %h", bus.iREN, bus.imemaddr, PC_INIT); end
    tick();
    RST = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    n_tests++;
    if (bus.imemaddr !== PC_INIT || bus.iien !== 1'b1 || bus.iREN !== 1'b1)
      begin n_fail++; $display("FAIL rst_restart got addr %h iien %b exp %h 1", bus.imemaddr, bus.iien, PC_INIT); end
    tick();
  endtask

  task automatic test_random();
    word_t m_pc, m_tgt, e_npc;
    bit    m_pend, m_halt, e_iien, e_iren, ih, stl, re, h;
    word_t rpc;
    test_reset();
    m_pc = PC_INIT; m_tgt = '0; m_pend = 0; m_halt = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, m_halt ? 7 : 60) == 0) begin
        RST = 1'b1;
        #2;
        n_tests++;
        if (bus.iREN !== 1'b0 || bus.iien !== 1'b0 || bus.imemaddr !== PC_INIT)
          begin n_fail++; $display("FAIL rnd_rst[%0d] got iren %b iien %b addr %h", c, bus.iREN, bus.iien, bus.imemaddr); end
        tick();
        RST = 1'b0;
        m_pc = PC_INIT; m_tgt = '0; m_pend = 0; m_halt = 0;
      end
      ih  = $urandom_range(0, 1) == 1;
      stl = $urandom_range(0, 3) == 0;
      re  = $urandom_range(0, 5) == 0;
      h   = $urandom_range(0, 80) == 0;
      rpc = $urandom;
      set_in(ih, stl, re, rpc, h);
      #2;
      e_iren = !m_halt;
      e_iien = !m_halt && !m_pend && ih && !stl && !re && !h;
      e_npc  = m_pc + 32'd4;
      n_tests++;
      if (bus.imemaddr !== m_pc || bus.iien !== e_iien || bus.iREN !== e_iren ||
          bus.npc_o !== e_npc || bus.iload_o !== bus.imemload)
        begin n_fail++; $display("FAIL rnd[%0d] got addr %h iien %b iren %b npc %h exp addr %h iien %b iren %b npc %h",
                                 c, bus.imemaddr, bus.iien, bus.iREN, bus.npc_o, m_pc, e_iien, e_iren, e_npc); end
      // model: a miss that was overtaken by a redirect is thrown away and the newest target fetched
      if (!m_halt) begin
        if (h) m_halt = 1;
        else if (m_pend) begin
          if (ih) begin m_pc = re ? (rpc & ~32'h3) : m_tgt; m_pend = 0; end
          else if (re) m_tgt = rpc & ~32'h3;
        end else if (re) begin
          if (ih) m_pc = rpc & ~32'h3;
          else begin m_tgt = rpc & ~32'h3; m_pend = 1; end
        end else if (ih && !stl) m_pc = m_pc + 32'd4;
      end
      tick();
    end
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    test_reset();
    test_sequential();
    test_miss();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
